// File: rtl/button_conditioner_pkg.sv
// Shared constants for the pushbutton front end (12 MHz board clock).
// Optional auto-repeat is enabled with BUTTON_CONDITIONER_REPEAT_EN.
package button_conditioner_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 12000;
    localparam int DEF_HOLD_CYCLES     = 6000000;
    localparam int DEF_REPEAT_CYCLES   = 1200000;
    localparam bit DEF_ACTIVE_LOW      = 1'b1;

    // Raw pin level of a button that is not being pressed.
    function automatic logic released_level(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_ch.sv
// One button channel: synchronizer, debounce, press-edge detect.
// Auto-repeat is built only with BUTTON_CONDITIONER_REPEAT_EN.
module debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic raw_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic REL = released_level(ACTIVE_LOW);

    logic          s1;
    logic          s2;
    logic          pressed;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_d;
    logic          pulse_q;
    logic          rep_fire;

    // Two-flop synchronizer on the raw pin level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= REL;
            s2 <= REL;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    assign pressed = s2 ^ ACTIVE_LOW;

    // Flip the stable state only after a long enough disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (pressed == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= pressed;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(HMAX) + 1;

    logic [HW-1:0] hold_cnt;
    logic          repeating;

    assign rep_fire = stable &
        (repeating ? (hold_cnt == HW'(REPEAT_CYCLES))
                   : (hold_cnt == HW'(HOLD_CYCLES)));

    // Time the held press: first repeat after the hold, then periodic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (!stable) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt  <= HW'(1);
            repeating <= 1'b1;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    localparam int unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;
    assign rep_fire = 1'b0;
`endif

    // Registered press-edge pulse; release edges are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            stable_d <= stable;
            pulse_q  <= (stable & ~stable_d) | rep_fire;
        end
    end

    assign level     = stable;
    assign raw_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Two-button front end producing clean up/down command pulses.
// Auto-repeat is built only with BUTTON_CONDITIONER_REPEAT_EN.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic up_level,
    output logic down_level
);

    logic pulse_up;
    logic pulse_down;

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_up (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_up_raw),
        .level     (up_level),
        .raw_pulse (pulse_up)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_down (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_down_raw),
        .level     (down_level),
        .raw_pulse (pulse_down)
    );

    // Coincident commands cancel so the counter never sees both.
    assign up   = pulse_up & ~pulse_down;
    assign down = pulse_down & ~pulse_up;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner against a behavioural model.
// Repeat expectations follow BUTTON_CONDITIONER_REPEAT_EN.
module tb_button_conditioner;

    localparam int D    = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic clk          = 1'b0;
    logic reset        = 1'b1;
    logic btn_up_raw   = 1'b1;
    logic btn_down_raw = 1'b1;
    logic up;
    logic down;
    logic up_level;
    logic down_level;

    int n_tests = 0;
    int n_fail  = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .up           (up),
        .down         (down),
        .up_level     (up_level),
        .down_level   (down_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: pressed samples reach the filter two edges
    // late; the level flips after D consecutive disagreeing samples;
    // a command appears one edge after the level rises; with repeat,
    // extra commands at press age HOLD, HOLD+REP, HOLD+2*REP, ...
    bit m_p0[2];
    bit m_p1[2];
    bit m_st[2];
    bit m_st_prev[2];
    bit m_rp[2];
    int m_run[2];
    int m_age[2];
    bit m_raw[2];
    bit syn;
    bit rep;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_p0[c] = 0; m_p1[c] = 0;
                m_st[c] = 0; m_st_prev[c] = 0;
                m_rp[c] = 0; m_run[c] = 0;
                m_age[c] = 0;
            end
        end else begin
            m_raw[0] = ~btn_up_raw;
            m_raw[1] = ~btn_down_raw;
            for (int c = 0; c < 2; c++) begin
                syn     = m_p1[c];
                m_p1[c] = m_p0[c];
                m_p0[c] = m_raw[c];
                rep     = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
                rep = m_st[c] && (m_age[c] == HOLD ||
                      (m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0));
`endif
                m_rp[c]      = (m_st[c] && !m_st_prev[c]) || rep;
                m_st_prev[c] = m_st[c];
                m_age[c]     = m_st[c] ? m_age[c] + 1 : 0;
                if (syn != m_st[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == D) begin
                    m_st[c]  = syn;
                    m_run[c] = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        check("up", up, m_rp[0] & ~m_rp[1]);
        check("down", down, m_rp[1] & ~m_rp[0]);
        check("up_level", up_level, m_st[0]);
        check("down_level", down_level, m_st[1]);
        check("never_both", up & down, 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit tu;
        bit td;
        bit gl;
        int len;
        int lat;
        int lvl;
        int cnt;

        step(3);
        #2 reset = 1'b0;
        step(5);
        check("idle_up_level", up_level, 0);
        check("idle_down_level", down_level, 0);

        // Clean press of up, held 30 cycles from edge 0.
        btn_up_raw = 1'b0;
        lat = -1; lvl = -1; cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (up) begin
                cnt++;
                if (lat < 0) lat = k;
            end
            if (up_level && lvl < 0) lvl = k;
        end
        check("press_latency", lat, 7);
        check("level_latency", lvl, 6);
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        check("press_pulses", cnt, 2);
`else
        check("press_pulses", cnt, 1);
`endif
        btn_up_raw = 1'b1;
        step(20);

        // Reset during debounce, button kept held.
        btn_up_raw = 1'b0;
        step(3);
        #2 reset = 1'b1;
        #1;
        check("reset_outputs", {up, down, up_level, down_level}, 0);
        step(1);
        #2 reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (up && lat < 0) lat = k;
        end
        check("reset_latency", lat, 7);
        btn_up_raw = 1'b1;
        step(20);

        // Random segments: steady targets, bounce, occasional reset.
        for (int s = 0; s < 60; s++) begin
            tu  = 1'($urandom_range(0, 1));
            td  = 1'($urandom_range(0, 1));
            gl  = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 35);
            for (int k = 0; k < len; k++) begin
                btn_up_raw   = tu ^ (gl && $urandom_range(0, 3) == 0);
                btn_down_raw = td ^ (gl && $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 199) == 0) begin
                    #2 reset = 1'b1;
                    step($urandom_range(1, 3));
                    #2 reset = 1'b0;
                end
                step(1);
            end
        end

        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        step(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
